chacha20_stream_feeder: RTL and testbench
=========================================

Name: chacha20_stream_feeder

Overview:
Upstream transmitter that drives the ChaCha20 encrypt/decrypt core's input stream. It accepts a per-message command (key, nonce, counter, beat count) and buffers payload words in a small FIFO. It pulses the core's start, streams words with valid/last under core backpressure, then waits for the core's done and reports a one-cycle response. It sits between the host/DMA side and the cipher core's plaintext/ciphertext input port.

Parameters:
DATA_WIDTH_WORDS, 1, payload width in 32-bit words; must match the core.
FIFO_DEPTH, 8, payload FIFO entries; power of two, >=2.
LEN_WIDTH, 16, width of the message beat count.

Ports:
clk  input  1  clock
rst  input  1  reset, asynchronous, active-high
cmd_valid  input  1  command present
cmd_ready  output  1  command accepted when cmd_valid && cmd_ready
cmd_key  input  256  key
cmd_nonce  input  96  nonce
cmd_counter  input  32  initial block counter
cmd_len  input  LEN_WIDTH  message length in beats
in_data  input  32*DATA_WIDTH_WORDS  payload word
in_valid  input  1  payload present
in_ready  output  1  FIFO not full
core_start  output  1  one-cycle start pulse to the core
core_key  output  256  latched key
core_nonce  output  96  latched nonce
core_counter  output  32  latched counter
core_data  output  32*DATA_WIDTH_WORDS  FIFO head
core_valid  output  1  beat valid
core_last  output  1  final beat of the message
core_ready  input  1  core accepts beat
core_done  input  1  core finished the message
rsp_valid  output  1  one-cycle message-complete pulse
rsp_error  output  1  qualified by rsp_valid; core_done arrived before the last beat
busy  output  1  state != IDLE
beats_sent  output  LEN_WIDTH  beats transferred in the current message

Behaviour:
- Reset (async, immediate): state=IDLE; FIFO empty; key/nonce/counter/remaining/beats_sent=0. Outputs: core_start=core_valid=core_last=rsp_valid=rsp_error=busy=0; core_data=FIFO head (don't-care when core_valid=0); cmd_ready=1; in_ready=1.
- FIFO:
  - Writes accepted in any state when in_valid && in_ready; in_ready = !full.
  - Fall-through read: a word written in cycle N appears on core_data in cycle N+1 if the FIFO was empty.
  - Simultaneous push and pop leaves the count unchanged.
  - Pointers wrap modulo FIFO_DEPTH.
  - Preloading before the command is allowed.
- FSM:
  - IDLE: cmd_ready=1. On accept, latch key/nonce/counter, remaining=cmd_len, beats_sent=0.
    - cmd_len==0: stay IDLE; rsp_valid=1, rsp_error=0 in the next cycle; no core_start.
    - otherwise go to START.
  - START: core_start=1 for exactly one cycle, then STREAM. core_key/nonce/counter stay stable from START until the return to IDLE.
  - STREAM:
    - core_valid = !fifo_empty; core_last = core_valid && remaining==1.
    - Transfer on core_valid && core_ready: pop, remaining--, beats_sent++.
    - While core_valid && !core_ready, core_data/core_last hold stable (AXI-stream rule).
    - Last transfer -> WAIT_DONE.
    - core_done in STREAM: flush FIFO, go IDLE, pulse rsp_valid with rsp_error=1 next cycle.
  - WAIT_DONE: core_valid=0. On core_done, go IDLE and pulse rsp_valid with rsp_error=0 in the next cycle.
- cmd_ready=0 outside IDLE. No new command overlaps an active message.
- Words beyond cmd_len stay in the FIFO for the next message.
- beats_sent saturates at 2^LEN_WIDTH-1; remaining never underflows.
- Latency from command accept (cycle N) to the first beat: core_start in N+1, first core_valid in N+2 if data is present.

Decomposition:
- Package chacha20_pkg: state enum (IDLE, START, STREAM, WAIT_DONE) and constants KEY_W=256, NONCE_W=96, CTR_W=32, WORD_W=32.
- One sub-module, chacha20_word_fifo: parameterised synchronous FIFO with fall-through, full/empty/count, async active-high reset, and flush input.

Test Plan:
1. Preload 0x11111111..0x44444444, cmd_len=4, core_ready=1 -> core_start one cycle after accept; 4 consecutive beats; core_last only on 0x44444444; core_done 2 cycles later -> rsp_valid=1, rsp_error=0, beats_sent=4.
2. Same message with core_ready pattern 1,0,1,0,... -> each word held stable while stalled; no drop or duplicate; beats_sent=4; last on 4th beat.
3. FIFO_DEPTH=8, write 10 words with no command -> in_ready falls after the 8th write; words 9-10 not accepted; FIFO count=8.
4. cmd_len=0 -> rsp_valid in the next cycle with rsp_error=0; core_start never asserted; cmd_ready stays 1.
5. cmd_len=4, core_done asserted after 2 beats -> rsp_valid with rsp_error=1; FIFO empty; state IDLE; busy=0.
6. Assert rst mid-STREAM after 1 beat -> core_valid, busy, core_start drop in the same cycle; after release cmd_ready=1, in_ready=1, beats_sent=0.

Source files
------------

// File: rtl/chacha20_pkg.sv
// Shared types and widths for the ChaCha20 stream feeder.
// FSM state encoding plus the fixed key/nonce/counter/word widths of the cipher core.
package chacha20_pkg;
   localparam int KEY_W   = 256;
   localparam int NONCE_W = 96;
   localparam int CTR_W   = 32;
   localparam int WORD_W  = 32;

   typedef enum logic [1:0] {
      IDLE      = 2'd0,
      START     = 2'd1,
      STREAM    = 2'd2,
      WAIT_DONE = 2'd3
   } state_e;
endpackage

// File: rtl/chacha20_word_fifo.sv
// Fall-through payload FIFO: the head entry is visible on rd_data the cycle after it is written.
// flush discards stored entries but keeps a word pushed in the same cycle.
module chacha20_word_fifo #(
   parameter int WIDTH = 32,
   parameter int DEPTH = 8
) (
   input  logic                     clk,
   input  logic                     rst,
   input  logic                     flush,
   input  logic                     push,
   input  logic [WIDTH-1:0]         wr_data,
   input  logic                     pop,
   output logic [WIDTH-1:0]         rd_data,
   output logic                     full,
   output logic                     empty,
   output logic [$clog2(DEPTH):0]   count
);
   localparam int AW = $clog2(DEPTH);
   localparam int CW = AW + 1;

   logic [WIDTH-1:0] mem_q [DEPTH];
   logic [AW-1:0]    wr_ptr_q, wr_ptr_d;
   logic [AW-1:0]    rd_ptr_q, rd_ptr_d;
   logic [CW-1:0]    count_q, count_d;
   logic             do_push, do_pop;

   assign full    = (count_q == CW'(DEPTH));
   assign empty   = (count_q == '0);
   assign count   = count_q;
   assign rd_data = mem_q[rd_ptr_q];
   assign do_push = push && !full;
   assign do_pop  = pop && !empty;

   always_comb begin
      wr_ptr_d = wr_ptr_q;
      rd_ptr_d = rd_ptr_q;
      count_d  = count_q;
      if (do_push) wr_ptr_d = wr_ptr_q + AW'(1);
      if (flush) begin
         rd_ptr_d = wr_ptr_q;
         count_d  = do_push ? CW'(1) : '0;
      end else begin
         if (do_pop) rd_ptr_d = rd_ptr_q + AW'(1);
         case ({do_push, do_pop})
            2'b10:   count_d = count_q + CW'(1);
            2'b01:   count_d = count_q - CW'(1);
            default: count_d = count_q;
         endcase
      end
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         wr_ptr_q <= '0;
         rd_ptr_q <= '0;
         count_q  <= '0;
      end else begin
         wr_ptr_q <= wr_ptr_d;
         rd_ptr_q <= rd_ptr_d;
         count_q  <= count_d;
      end
   end

   always_ff @(posedge clk) begin
      if (do_push) mem_q[wr_ptr_q] <= wr_data;
   end
endmodule

// File: rtl/chacha20_stream_feeder.sv
// Feeds one message at a time into the ChaCha20 core: latch command, pulse start,
// stream buffered payload beats, then wait for the core's done and report a response.
module chacha20_stream_feeder
   import chacha20_pkg::*;
#(
   parameter int DATA_WIDTH_WORDS = 1,
   parameter int FIFO_DEPTH       = 8,
   parameter int LEN_WIDTH        = 16
) (
   input  logic                             clk,
   input  logic                             rst,
   input  logic                             cmd_valid,
   output logic                             cmd_ready,
   input  logic [KEY_W-1:0]                 cmd_key,
   input  logic [NONCE_W-1:0]               cmd_nonce,
   input  logic [CTR_W-1:0]                 cmd_counter,
   input  logic [LEN_WIDTH-1:0]             cmd_len,
   input  logic [WORD_W*DATA_WIDTH_WORDS-1:0] in_data,
   input  logic                             in_valid,
   output logic                             in_ready,
   output logic                             core_start,
   output logic [KEY_W-1:0]                 core_key,
   output logic [NONCE_W-1:0]               core_nonce,
   output logic [CTR_W-1:0]                 core_counter,
   output logic [WORD_W*DATA_WIDTH_WORDS-1:0] core_data,
   output logic                             core_valid,
   output logic                             core_last,
   input  logic                             core_ready,
   input  logic                             core_done,
   output logic                             rsp_valid,
   output logic                             rsp_error,
   output logic                             busy,
   output logic [LEN_WIDTH-1:0]             beats_sent
);
   localparam int DW    = WORD_W * DATA_WIDTH_WORDS;
   localparam int CNT_W = $clog2(FIFO_DEPTH) + 1;

   state_e               state_q, state_d;
   logic [KEY_W-1:0]     key_q, key_d;
   logic [NONCE_W-1:0]   nonce_q, nonce_d;
   logic [CTR_W-1:0]     ctr_q, ctr_d;
   logic [LEN_WIDTH-1:0] remaining_q, remaining_d;
   logic [LEN_WIDTH-1:0] beats_q, beats_d;
   logic                 rsp_valid_q, rsp_valid_d;
   logic                 rsp_error_q, rsp_error_d;
   logic                 fifo_pop, fifo_flush, fifo_full, fifo_empty;
   logic [CNT_W-1:0]     fifo_count;

   chacha20_word_fifo #(.WIDTH(DW), .DEPTH(FIFO_DEPTH)) u_fifo (
      .clk     (clk),
      .rst     (rst),
      .flush   (fifo_flush),
      .push    (in_valid),
      .wr_data (in_data),
      .pop     (fifo_pop),
      .rd_data (core_data),
      .full    (fifo_full),
      .empty   (fifo_empty),
      .count   (fifo_count)
   );

   // Every channel (cmd, in, core) transfers on the rising edge where valid && ready;
   // a valid beat keeps its data and last flag stable until that transfer happens.
   always_comb begin
      state_d     = state_q;
      key_d       = key_q;
      nonce_d     = nonce_q;
      ctr_d       = ctr_q;
      remaining_d = remaining_q;
      beats_d     = beats_q;
      rsp_valid_d = 1'b0;
      rsp_error_d = 1'b0;
      cmd_ready   = 1'b0;
      core_start  = 1'b0;
      core_valid  = 1'b0;
      core_last   = 1'b0;
      fifo_pop    = 1'b0;
      fifo_flush  = 1'b0;
      case (state_q)
         IDLE: begin
            cmd_ready = 1'b1;
            if (cmd_valid) begin
               key_d       = cmd_key;
               nonce_d     = cmd_nonce;
               ctr_d       = cmd_counter;
               remaining_d = cmd_len;
               beats_d     = '0;
               if (cmd_len == '0) rsp_valid_d = 1'b1;
               else               state_d     = START;
            end
         end
         START: begin
            core_start = 1'b1;
            state_d    = STREAM;
         end
         STREAM: begin
            core_valid = !fifo_empty;
            core_last  = core_valid && (remaining_q == LEN_WIDTH'(1));
            if (core_done) begin
               // Early done aborts the message; leftover payload is dropped.
               fifo_flush  = 1'b1;
               state_d     = IDLE;
               rsp_valid_d = 1'b1;
               rsp_error_d = 1'b1;
            end else if (core_valid && core_ready) begin
               fifo_pop = 1'b1;
               if (remaining_q != '0) remaining_d = remaining_q - LEN_WIDTH'(1);
               if (beats_q != '1)     beats_d     = beats_q + LEN_WIDTH'(1);
               if (remaining_q == LEN_WIDTH'(1)) state_d = WAIT_DONE;
            end
         end
         WAIT_DONE: begin
            if (core_done) begin
               state_d     = IDLE;
               rsp_valid_d = 1'b1;
            end
         end
         default: state_d = IDLE;
      endcase
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state_q     <= IDLE;
         key_q       <= '0;
         nonce_q     <= '0;
         ctr_q       <= '0;
         remaining_q <= '0;
         beats_q     <= '0;
         rsp_valid_q <= 1'b0;
         rsp_error_q <= 1'b0;
      end else begin
         state_q     <= state_d;
         key_q       <= key_d;
         nonce_q     <= nonce_d;
         ctr_q       <= ctr_d;
         remaining_q <= remaining_d;
         beats_q     <= beats_d;
         rsp_valid_q <= rsp_valid_d;
         rsp_error_q <= rsp_error_d;
      end
   end

   assign in_ready     = !fifo_full;
   assign core_key     = key_q;
   assign core_nonce   = nonce_q;
   assign core_counter = ctr_q;
   assign rsp_valid    = rsp_valid_q;
   assign rsp_error    = rsp_error_q;
   assign busy         = (state_q != IDLE);
   assign beats_sent   = beats_q;

   fifo_count_consistent: assert property (@(posedge clk) disable iff (rst)
      fifo_full == (fifo_count == CNT_W'(FIFO_DEPTH)));
endmodule

// File: tb/tb_chacha20_stream_feeder.sv
// Bench for chacha20_stream_feeder: table of message scenarios, a FIFO-fill sequence and
// randomized messages, all checked against a queue model of the payload stream.
module tb_chacha20_stream_feeder;
   localparam int DEPTH = 8;
   localparam int LW    = 16;

   logic          clk = 1'b0;
   logic          rst;
   logic          cmd_valid, cmd_ready;
   logic [255:0]  cmd_key;
   logic [95:0]   cmd_nonce;
   logic [31:0]   cmd_counter;
   logic [LW-1:0] cmd_len;
   logic [31:0]   in_data;
   logic          in_valid, in_ready;
   logic          core_start;
   logic [255:0]  core_key;
   logic [95:0]   core_nonce;
   logic [31:0]   core_counter;
   logic [31:0]   core_data;
   logic          core_valid, core_last, core_ready, core_done;
   logic          rsp_valid, rsp_error, busy;
   logic [LW-1:0] beats_sent;

   chacha20_stream_feeder #(.DATA_WIDTH_WORDS(1), .FIFO_DEPTH(DEPTH), .LEN_WIDTH(LW)) dut (
      .clk(clk), .rst(rst),
      .cmd_valid(cmd_valid), .cmd_ready(cmd_ready), .cmd_key(cmd_key), .cmd_nonce(cmd_nonce),
      .cmd_counter(cmd_counter), .cmd_len(cmd_len),
      .in_data(in_data), .in_valid(in_valid), .in_ready(in_ready),
      .core_start(core_start), .core_key(core_key), .core_nonce(core_nonce),
      .core_counter(core_counter), .core_data(core_data), .core_valid(core_valid),
      .core_last(core_last), .core_ready(core_ready), .core_done(core_done),
      .rsp_valid(rsp_valid), .rsp_error(rsp_error), .busy(busy), .beats_sent(beats_sent)
   );

   always #5 clk = ~clk;

   int tests_run = 0;
   int tests_failed = 0;
   logic [31:0] exp_q[$];

   typedef struct {
      int   npre;
      logic fixed;
      int   len;
      int   mode;      // 0 always ready, 1 alternating, 2 random
      int   kind;      // 0 normal done, 1 early done, 2 reset mid-stream
      int   abort_at;
      logic exp_err;
      int   exp_beats;
   } vec_t;

   vec_t vecs[7];

   task automatic check(input string name, input logic [255:0] act, input logic [255:0] exp);
      tests_run++;
      if (act !== exp) begin
         tests_failed++;
         $display("FAIL %s: got %0h expected %0h", name, act, exp);
      end
   endtask

   task automatic idle_inputs();
      cmd_valid  = 1'b0;
      in_valid   = 1'b0;
      core_ready = 1'b0;
      core_done  = 1'b0;
   endtask

   // Called at a negedge; asserts reset asynchronously and releases at the next negedge.
   task automatic apply_reset_async();
      rst = 1'b1;
      #1;
      check("rst_core_valid", core_valid, 1'b0);
      check("rst_busy", busy, 1'b0);
      check("rst_core_start", core_start, 1'b0);
      idle_inputs();
      exp_q.delete();
      @(negedge clk);
      rst = 1'b0;
      check("rst_cmd_ready", cmd_ready, 1'b1);
      check("rst_in_ready", in_ready, 1'b1);
      check("rst_beats_sent", beats_sent, '0);
   endtask

   task automatic preload(input int n, input logic fixed, output int acc);
      logic [31:0] w;
      acc = 0;
      for (int i = 0; i < n; i++) begin
         w = fixed ? 32'h11111111 * (i + 1) : $urandom;
         check("in_ready", in_ready, exp_q.size() < DEPTH);
         in_valid = 1'b1;
         in_data  = w;
         if (in_ready) begin
            exp_q.push_back(w);
            acc++;
         end
         @(negedge clk);
      end
      in_valid = 1'b0;
   endtask

   task automatic run_msg(input int len, input int mode, input int kind, input int abort_at,
                          input logic exp_err, input int exp_beats);
      logic [255:0] key;
      logic [95:0]  nonce;
      logic [31:0]  ctr;
      int           beats, stop;
      logic         rdy;
      for (int k = 0; k < 8; k++) key[k*32 +: 32] = $urandom;
      for (int k = 0; k < 3; k++) nonce[k*32 +: 32] = $urandom;
      ctr = $urandom;
      check("cmd_ready_idle", cmd_ready, 1'b1);
      cmd_valid   = 1'b1;
      cmd_key     = key;
      cmd_nonce   = nonce;
      cmd_counter = ctr;
      cmd_len     = LW'(len);
      @(negedge clk);
      cmd_valid = 1'b0;
      if (len == 0) begin
         check("len0_rsp_valid", rsp_valid, 1'b1);
         check("len0_rsp_error", rsp_error, 1'b0);
         check("len0_no_start", core_start, 1'b0);
         check("len0_cmd_ready", cmd_ready, 1'b1);
         @(negedge clk);
         check("len0_rsp_pulse", rsp_valid, 1'b0);
         check("len0_still_no_start", core_start, 1'b0);
         return;
      end
      check("start_pulse", core_start, 1'b1);
      check("start_busy", busy, 1'b1);
      check("start_cmd_ready", cmd_ready, 1'b0);
      check("core_key", core_key, key);
      check("core_nonce", core_nonce, nonce);
      check("core_counter", core_counter, ctr);
      stop  = (kind == 0) ? len : abort_at;
      beats = 0;
      for (int cyc = 0; cyc < 400; cyc++) begin
         if (cyc == 1) begin
            check("start_one_cycle", core_start, 1'b0);
            check("first_valid_latency", core_valid, exp_q.size() > 0);
         end
         if (core_valid) begin
            check("core_data", core_data, (exp_q.size() > 0) ? exp_q[0] : 32'hx);
            check("core_last", core_last, beats == len - 1);
         end
         check("beats_sent", beats_sent, LW'(beats));
         if (beats == stop) break;
         rdy = (mode == 0) || (mode == 1 && cyc % 2 == 1) ||
               (mode == 2 && $urandom_range(0, 1) == 1);
         core_ready = rdy;
         if (core_valid && rdy && exp_q.size() > 0) begin
            void'(exp_q.pop_front());
            beats++;
         end
         @(negedge clk);
      end
      core_ready = 1'b0;
      check("beats_reached", beats, stop);
      if (kind == 0) begin
         check("wait_core_valid", core_valid, 1'b0);
         check("wait_busy", busy, 1'b1);
         check("wait_key_stable", core_key, key);
         repeat (2) @(negedge clk);
         core_done = 1'b1;
         @(negedge clk);
         core_done = 1'b0;
         check("rsp_valid", rsp_valid, 1'b1);
         check("rsp_error", rsp_error, exp_err);
         check("rsp_busy", busy, 1'b0);
         check("rsp_cmd_ready", cmd_ready, 1'b1);
         check("rsp_beats_sent", beats_sent, LW'(exp_beats));
         @(negedge clk);
         check("rsp_pulse", rsp_valid, 1'b0);
      end else if (kind == 1) begin
         core_done = 1'b1;
         @(negedge clk);
         core_done = 1'b0;
         exp_q.delete();
         check("abort_rsp_valid", rsp_valid, 1'b1);
         check("abort_rsp_error", rsp_error, exp_err);
         check("abort_busy", busy, 1'b0);
         check("abort_core_valid", core_valid, 1'b0);
         check("abort_cmd_ready", cmd_ready, 1'b1);
         check("abort_beats_sent", beats_sent, LW'(exp_beats));
         @(negedge clk);
         check("abort_rsp_pulse", rsp_valid, 1'b0);
      end else begin
         apply_reset_async();
      end
   endtask

   initial begin
      #200000;
      tests_failed++;
      $display("FAIL watchdog: got timeout expected completion");
      $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
      $finish;
   end

   initial begin
      int acc, npre, len;
      vecs[0] = '{4, 1'b1, 4, 0, 0, 0, 1'b0, 4};
      vecs[1] = '{4, 1'b1, 4, 1, 0, 0, 1'b0, 4};
      vecs[2] = '{0, 1'b0, 0, 0, 0, 0, 1'b0, 0};
      vecs[3] = '{4, 1'b1, 4, 0, 1, 2, 1'b1, 2};
      vecs[4] = '{6, 1'b0, 3, 2, 0, 0, 1'b0, 3};
      vecs[5] = '{0, 1'b0, 3, 1, 0, 0, 1'b0, 3};
      vecs[6] = '{3, 1'b1, 3, 0, 2, 1, 1'b0, 0};

      rst = 1'b1;
      idle_inputs();
      cmd_key = '0; cmd_nonce = '0; cmd_counter = '0; cmd_len = '0; in_data = '0;
      repeat (3) @(negedge clk);
      check("reset_cmd_ready", cmd_ready, 1'b1);
      check("reset_in_ready", in_ready, 1'b1);
      check("reset_core_start", core_start, 1'b0);
      check("reset_core_valid", core_valid, 1'b0);
      check("reset_core_last", core_last, 1'b0);
      check("reset_rsp_valid", rsp_valid, 1'b0);
      check("reset_rsp_error", rsp_error, 1'b0);
      check("reset_busy", busy, 1'b0);
      check("reset_beats_sent", beats_sent, '0);
      check("reset_core_key", core_key, '0);
      rst = 1'b0;
      @(negedge clk);

      for (int v = 0; v < 7; v++) begin
         preload(vecs[v].npre, vecs[v].fixed, acc);
         run_msg(vecs[v].len, vecs[v].mode, vecs[v].kind, vecs[v].abort_at,
                 vecs[v].exp_err, vecs[v].exp_beats);
         @(negedge clk);
      end

      // Overfill with no command pending: only DEPTH words may be taken.
      preload(10, 1'b1, acc);
      check("fill_accepted", acc, DEPTH);
      check("fill_in_ready_low", in_ready, 1'b0);
      check("fill_idle", busy, 1'b0);
      run_msg(DEPTH, 0, 0, 0, 1'b0, DEPTH);
      check("drained_in_ready", in_ready, 1'b1);
      @(negedge clk);

      for (int r = 0; r < 20; r++) begin
         npre = $urandom_range(0, DEPTH - exp_q.size());
         preload(npre, 1'b0, acc);
         len = $urandom_range(0, exp_q.size());
         run_msg(len, 2, 0, 0, 1'b0, len);
         @(negedge clk);
      end

      $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
      $finish;
   end
endmodule
